// File: rtl/vga_timing_pkg.sv
// Default 640x480 raster timing and width/total helpers shared by the VGA timing engine.
package vga_timing_pkg;

   localparam int unsigned DefWidth  = 640;
   localparam int unsigned DefHeight = 480;
   localparam int unsigned DefHFp    = 16;
   localparam int unsigned DefHSync  = 96;
   localparam int unsigned DefHBp    = 48;
   localparam int unsigned DefVFp    = 11;
   localparam int unsigned DefVSync  = 2;
   localparam int unsigned DefVBp    = 31;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int unsigned h_total(input int unsigned width, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return width + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned height, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return height + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// Raster timing bundle between the timing engine (master) and the pixel-fetch/colour path.
interface vga_timing_engine_if
   import vga_timing_pkg::*;
#(
   parameter int unsigned X_W     = clog2(h_total(DefWidth, DefHFp, DefHSync, DefHBp)),
   parameter int unsigned Y_W     = clog2(v_total(DefHeight, DefVFp, DefVSync, DefVBp)),
   parameter int unsigned FRAME_W = 16
);
   logic               pix_en;
   logic               frame_restart;
   logic [X_W-1:0]     x_ahead;
   logic [Y_W-1:0]     y_ahead;
   logic               active_ahead;
   logic               active;
   logic               hsync;
   logic               vsync;
   logic               line_end;
   logic               screen_end;
   logic [FRAME_W-1:0] frame_count;

   modport master (
      input  pix_en, frame_restart,
      output x_ahead, y_ahead, active_ahead, active, hsync, vsync, line_end, screen_end,
             frame_count
   );

   modport slave (
      output pix_en, frame_restart,
      input  x_ahead, y_ahead, active_ahead, active, hsync, vsync, line_end, screen_end,
             frame_count
   );

endinterface

// File: rtl/vga_sig_delay.sv
// Enabled shift register of DEPTH stages, cleared to zero on reset; DEPTH=0 is a wire.
module vga_sig_delay #(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk_i, rst_ni, en_i};
      assign q_o = d_i;
   end else begin : g_pipe
      logic [W-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA raster generator: lead counters and coordinates, with sync/active/pulse
// outputs delayed LOOKAHEAD enabled cycles so framebuffer read latency is hidden.
module vga_timing_engine
   import vga_timing_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned HEIGHT     = DefHeight,
   parameter int unsigned H_FP       = DefHFp,
   parameter int unsigned H_SYNC     = DefHSync,
   parameter int unsigned H_BP       = DefHBp,
   parameter int unsigned V_FP       = DefVFp,
   parameter int unsigned V_SYNC     = DefVSync,
   parameter int unsigned V_BP       = DefVBp,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0,
   parameter int unsigned LOOKAHEAD  = 2,
   parameter int unsigned FRAME_W    = 16
) (
   input logic                 clk25,
   input logic                 reset_n,
   vga_timing_engine_if.master bus
);

   localparam int unsigned H_TOTAL = h_total(WIDTH, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = v_total(HEIGHT, V_FP, V_SYNC, V_BP);
   localparam int unsigned X_W     = clog2(H_TOTAL);
   localparam int unsigned Y_W     = clog2(V_TOTAL);

   // Inclusive bounds so no constant needs to reach 2**X_W when a back porch is zero.
   localparam logic [X_W-1:0] HLast      = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] HVisLast   = X_W'(WIDTH - 1);
   localparam logic [X_W-1:0] HSyncFirst = X_W'(WIDTH + H_FP);
   localparam logic [X_W-1:0] HSyncLast  = X_W'(WIDTH + H_FP + H_SYNC - 1);
   localparam logic [Y_W-1:0] VLast      = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] VVisLast   = Y_W'(HEIGHT - 1);
   localparam logic [Y_W-1:0] VSyncFirst = Y_W'(HEIGHT + V_FP);
   localparam logic [Y_W-1:0] VSyncLast  = Y_W'(HEIGHT + V_FP + V_SYNC - 1);

   logic [X_W-1:0]     h_q, h_d;
   logic [Y_W-1:0]     v_q, v_d;
   logic [FRAME_W-1:0] frame_q, frame_d;

   logic       h_vis, v_vis, vis, hs, vs, le, se;
   logic [4:0] lead_flags;
   logic [4:0] disp_flags;

   always_comb begin
      h_vis      = (h_q <= HVisLast);
      v_vis      = (v_q <= VVisLast);
      vis        = h_vis & v_vis;
      hs         = (h_q >= HSyncFirst) && (h_q <= HSyncLast);
      vs         = (v_q >= VSyncFirst) && (v_q <= VSyncLast);
      le         = (h_q == HLast);
      se         = le & (v_q == VLast);
      lead_flags = {vis, hs, vs, le, se};
   end

   always_comb begin
      h_d     = h_q;
      v_d     = v_q;
      frame_d = frame_q;
      if (bus.pix_en) begin
         if (le) begin
            h_d = '0;
            if (v_q == VLast) begin
               v_d     = '0;
               frame_d = frame_q + FRAME_W'(1);
            end else begin
               v_d = v_q + Y_W'(1);
            end
         end else begin
            h_d = h_q + X_W'(1);
         end
         // Restart overrides position only; a wrap on the same edge still counts the frame.
         if (bus.frame_restart) begin
            h_d = '0;
            v_d = '0;
         end
      end
   end

   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
      end
   end

   vga_sig_delay #(
      .W     (5),
      .DEPTH (LOOKAHEAD)
   ) u_delay (
      .clk_i  (clk25),
      .rst_ni (reset_n),
      .en_i   (bus.pix_en),
      .d_i    (lead_flags),
      .q_o    (disp_flags)
   );

   assign bus.x_ahead      = h_vis ? h_q : '0;
   assign bus.y_ahead      = v_vis ? v_q : '0;
   assign bus.active_ahead = vis;
   assign bus.frame_count  = frame_q;
   assign bus.active       = disp_flags[4];
   assign bus.hsync        = disp_flags[3] ? H_SYNC_POL : ~H_SYNC_POL;
   assign bus.vsync        = disp_flags[2] ? V_SYNC_POL : ~V_SYNC_POL;
   assign bus.line_end     = disp_flags[1];
   assign bus.screen_end   = disp_flags[0];

endmodule

// File: tb/tb_vga_timing_engine.sv
// Three engine configurations run side by side against a position-based raster model.
module tb_vga_timing_engine;

   typedef struct packed {
      int   width, height, hfp, hsw, hbp, vfp, vsw, vbp, la, fw;
      logic hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic [31:0] x, y, fc;
      logic        aa, act, hs, vs, le, se;
   } obs_t;

   logic clk = 1'b0;
   logic rsn [3];
   logic pen [3];
   logic rst [3];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: lead position, frame count, delay history (index 0 newest).
   int       mh [3];
   int       mv [3];
   int       mf [3];
   logic [4:0] mdl [3][16];

   always #5 clk = ~clk;

   vga_timing_engine_if #(.X_W(10), .Y_W(10), .FRAME_W(16)) bus_a ();
   vga_timing_engine_if #(.X_W(3),  .Y_W(3),  .FRAME_W(16)) bus_b ();
   vga_timing_engine_if #(.X_W(4),  .Y_W(3),  .FRAME_W(4))  bus_c ();

   assign bus_a.pix_en = pen[0];  assign bus_a.frame_restart = rst[0];
   assign bus_b.pix_en = pen[1];  assign bus_b.frame_restart = rst[1];
   assign bus_c.pix_en = pen[2];  assign bus_c.frame_restart = rst[2];

   vga_timing_engine u_dut_a (.clk25(clk), .reset_n(rsn[0]), .bus(bus_a));

   vga_timing_engine #(
      .WIDTH(4), .HEIGHT(2), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LOOKAHEAD(0), .FRAME_W(16)
   ) u_dut_b (.clk25(clk), .reset_n(rsn[1]), .bus(bus_b));

   vga_timing_engine #(
      .WIDTH(6), .HEIGHT(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .LOOKAHEAD(3), .FRAME_W(4)
   ) u_dut_c (.clk25(clk), .reset_n(rsn[2]), .bus(bus_c));

   function automatic cfg_t get_cfg(input int id);
      cfg_t c;
      case (id)
         0: c = '{width:640, height:480, hfp:16, hsw:96, hbp:48, vfp:11, vsw:2, vbp:31,
                  la:2, fw:16, hpol:1'b0, vpol:1'b0};
         1: c = '{width:4, height:2, hfp:1, hsw:1, hbp:1, vfp:1, vsw:1, vbp:1,
                  la:0, fw:16, hpol:1'b1, vpol:1'b1};
         default: c = '{width:6, height:4, hfp:2, hsw:3, hbp:1, vfp:1, vsw:2, vbp:1,
                        la:3, fw:4, hpol:1'b1, vpol:1'b0};
      endcase
      return c;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, got, got, exp, exp, $time);
      end
   endtask

   // {vis, hs, vs, le, se} for the model's current lead position.
   function automatic logic [4:0] lead_flags(input int id);
      cfg_t c = get_cfg(id);
      int   htot = c.width + c.hfp + c.hsw + c.hbp;
      int   vtot = c.height + c.vfp + c.vsw + c.vbp;
      logic vis = (mh[id] < c.width) && (mv[id] < c.height);
      logic hs  = (mh[id] >= c.width + c.hfp) && (mh[id] < c.width + c.hfp + c.hsw);
      logic vs  = (mv[id] >= c.height + c.vfp) && (mv[id] < c.height + c.vfp + c.vsw);
      logic le  = (mh[id] == htot - 1);
      logic se  = le && (mv[id] == vtot - 1);
      return {vis, hs, vs, le, se};
   endfunction

   task automatic model_reset(input int id);
      mh[id] = 0;
      mv[id] = 0;
      mf[id] = 0;
      for (int k = 0; k < 16; k++) mdl[id][k] = 5'b0;
   endtask

   task automatic model_step(input int id);
      cfg_t c = get_cfg(id);
      int   htot = c.width + c.hfp + c.hsw + c.hbp;
      int   vtot = c.height + c.vfp + c.vsw + c.vbp;
      logic last;
      if (!rsn[id]) begin
         model_reset(id);
         return;
      end
      if (!pen[id]) return;
      for (int k = 15; k > 0; k--) mdl[id][k] = mdl[id][k-1];
      mdl[id][0] = lead_flags(id);
      last = (mh[id] == htot - 1) && (mv[id] == vtot - 1);
      if (last) mf[id] = (mf[id] + 1) % (1 << c.fw);
      if (rst[id] || last) begin
         mh[id] = 0;
         mv[id] = 0;
      end else if (mh[id] == htot - 1) begin
         mh[id] = 0;
         mv[id]++;
      end else begin
         mh[id]++;
      end
   endtask

   function automatic obs_t expected(input int id);
      cfg_t       c = get_cfg(id);
      obs_t       e;
      logic [4:0] lf = lead_flags(id);
      logic [4:0] f  = (c.la == 0) ? lf : mdl[id][c.la-1];
      e.x   = (mh[id] < c.width)  ? 32'(mh[id]) : 32'd0;
      e.y   = (mv[id] < c.height) ? 32'(mv[id]) : 32'd0;
      e.fc  = 32'(mf[id]);
      e.aa  = lf[4];
      e.act = f[4];
      e.hs  = f[3] ? c.hpol : ~c.hpol;
      e.vs  = f[2] ? c.vpol : ~c.vpol;
      e.le  = f[1];
      e.se  = f[0];
      return e;
   endfunction

   function automatic obs_t read_dut(input int id);
      obs_t o;
      case (id)
         0: o = '{x:32'(bus_a.x_ahead), y:32'(bus_a.y_ahead), fc:32'(bus_a.frame_count),
                  aa:bus_a.active_ahead, act:bus_a.active, hs:bus_a.hsync, vs:bus_a.vsync,
                  le:bus_a.line_end, se:bus_a.screen_end};
         1: o = '{x:32'(bus_b.x_ahead), y:32'(bus_b.y_ahead), fc:32'(bus_b.frame_count),
                  aa:bus_b.active_ahead, act:bus_b.active, hs:bus_b.hsync, vs:bus_b.vsync,
                  le:bus_b.line_end, se:bus_b.screen_end};
         default: o = '{x:32'(bus_c.x_ahead), y:32'(bus_c.y_ahead),
                        fc:32'(bus_c.frame_count), aa:bus_c.active_ahead, act:bus_c.active,
                        hs:bus_c.hsync, vs:bus_c.vsync, le:bus_c.line_end,
                        se:bus_c.screen_end};
      endcase
      return o;
   endfunction

   task automatic check_all(input int id);
      string nm = (id == 0) ? "A" : (id == 1) ? "B" : "C";
      obs_t  o  = read_dut(id);
      obs_t  e  = expected(id);
      check_val({nm, ".x_ahead"},      o.x,   e.x);
      check_val({nm, ".y_ahead"},      o.y,   e.y);
      check_val({nm, ".frame_count"},  o.fc,  e.fc);
      check_val({nm, ".active_ahead"}, o.aa,  e.aa);
      check_val({nm, ".active"},       o.act, e.act);
      check_val({nm, ".hsync"},        o.hs,  e.hs);
      check_val({nm, ".vsync"},        o.vs,  e.vs);
      check_val({nm, ".line_end"},     o.le,  e.le);
      check_val({nm, ".screen_end"},   o.se,  e.se);
   endtask

   task automatic tick();
      @(posedge clk);
      for (int id = 0; id < 3; id++) model_step(id);
      #1;
      for (int id = 0; id < 3; id++) check_all(id);
   endtask

   initial begin
      int e, n, hs_hi, vs_hi, se_cnt, first, second;
      logic prev;
      for (int id = 0; id < 3; id++) begin
         rsn[id] = 1'b1;
         pen[id] = 1'b0;
         rst[id] = 1'b0;
      end
      #1;
      for (int id = 0; id < 3; id++) begin
         rsn[id] = 1'b0;
         model_reset(id);
      end
      #1;
      // Reset values from the reset rules themselves.
      check_val("A.rst active_ahead", bus_a.active_ahead, 1);
      check_val("A.rst active", bus_a.active, 0);
      check_val("A.rst hsync", bus_a.hsync, 1);
      check_val("A.rst vsync", bus_a.vsync, 1);
      check_val("B.rst active", bus_b.active, 1);
      check_val("B.rst hsync", bus_b.hsync, 0);
      check_val("C.rst vsync", bus_c.vsync, 1);
      check_val("C.rst hsync", bus_c.hsync, 0);
      for (int id = 0; id < 3; id++) check_all(id);
      for (int id = 0; id < 3; id++) pen[id] = 1'b1;
      tick();
      tick();
      for (int id = 0; id < 3; id++) rsn[id] = 1'b1;

      // Release: active follows two edges after the lead coordinates.
      check_val("A.t1 active_ahead at release", bus_a.active_ahead, 1);
      check_val("A.t1 active at release", bus_a.active, 0);
      tick();
      check_val("A.t1 active edge1", bus_a.active, 0);
      tick();
      check_val("A.t1 active edge2", bus_a.active, 1);
      e = 2;
      while (bus_a.hsync == 1'b1 && e < 2000) begin
         tick();
         e++;
      end
      check_val("A.t1 first hsync low edge", e, 658);
      n = 0;
      while (bus_a.hsync == 1'b0 && n < 200) begin
         tick();
         n++;
      end
      check_val("A.t1 hsync low width", n, 96);

      // Restart from the back porch of line 2.
      n = 0;
      while (!(mh[0] == 700 && mv[0] == 2) && n < 3000) begin
         tick();
         n++;
      end
      check_val("A.t4 reached (700,2)", (mh[0] == 700 && mv[0] == 2), 1);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      check_val("A.t4 x_ahead", bus_a.x_ahead, 0);
      check_val("A.t4 y_ahead", bus_a.y_ahead, 0);
      check_val("A.t4 active_ahead", bus_a.active_ahead, 1);
      check_val("A.t4 frame_count", bus_a.frame_count, 0);
      check_val("A.t4 old pos 1", bus_a.active, 0);
      tick();
      check_val("A.t4 old pos 2", bus_a.active, 0);
      tick();
      check_val("A.t4 new (0,0)", bus_a.active, 1);

      // Asynchronous reset inside the hsync pulse, with no clock edge.
      n = 0;
      while (mh[0] != 660 && n < 1000) begin
         tick();
         n++;
      end
      check_val("A.t5 hsync before reset", bus_a.hsync, 0);
      check_val("A.t5 active_ahead before reset", bus_a.active_ahead, 0);
      rsn[0] = 1'b0;
      model_reset(0);
      #1;
      check_val("A.t5 hsync", bus_a.hsync, 1);
      check_val("A.t5 vsync", bus_a.vsync, 1);
      check_val("A.t5 active", bus_a.active, 0);
      check_val("A.t5 active_ahead", bus_a.active_ahead, 1);
      check_val("A.t5 x_ahead", bus_a.x_ahead, 0);
      tick();
      rsn[0] = 1'b1;

      // Tiny raster: 7x5, positive syncs, no lookahead.
      rsn[1] = 1'b0;
      model_reset(1);
      #1;
      check_val("B.t6 reset active", bus_b.active, 1);
      check_val("B.t6 reset hsync", bus_b.hsync, 0);
      tick();
      rsn[1] = 1'b1;
      hs_hi = 0; vs_hi = 0; se_cnt = 0;
      for (int k = 0; k < 35; k++) begin
         tick();
         hs_hi  += int'(bus_b.hsync);
         vs_hi  += int'(bus_b.vsync);
         se_cnt += int'(bus_b.screen_end);
      end
      check_val("B.t6 hsync high cycles", hs_hi, 5);
      check_val("B.t6 vsync high cycles", vs_hi, 7);
      check_val("B.t6 screen_end pulses", se_cnt, 1);
      check_val("B.t6 frame_count", bus_b.frame_count, 1);
      n = 0;
      while (!(mh[1] == 6 && mv[1] == 4) && n < 100) begin
         tick();
         n++;
      end
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      check_val("B.restart at last pixel frame_count", bus_b.frame_count, 2);
      check_val("B.restart at last pixel x", bus_b.x_ahead, 0);

      // Frame period, frame count and vsync width on the 12x8 raster.
      rsn[2] = 1'b0;
      model_reset(2);
      tick();
      rsn[2] = 1'b1;
      e = 0;
      while (!bus_c.screen_end && e < 300) begin
         tick();
         e++;
      end
      check_val("C.t2 first screen_end edge", e, 98);
      check_val("C.t2 frame_count after 1", bus_c.frame_count, 1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus_c.screen_end && n < 300);
      check_val("C.t2 screen_end spacing", n, 96);
      check_val("C.t2 frame_count after 2", bus_c.frame_count, 2);
      n = 0;
      for (int k = 0; k < 96; k++) begin
         tick();
         n += int'(!bus_c.vsync);
      end
      check_val("C.t2 vsync low per frame", n, 24);

      // Half-rate pix_en doubles the frame period in clocks.
      rsn[2] = 1'b0;
      model_reset(2);
      tick();
      rsn[2] = 1'b1;
      first = -1; second = -1; prev = bus_c.screen_end;
      for (int k = 0; k < 600 && second < 0; k++) begin
         pen[2] = (k % 2 == 0);
         tick();
         if (bus_c.screen_end && !prev) begin
            if (first < 0) first = k;
            else second = k;
         end
         prev = bus_c.screen_end;
      end
      check_val("C.t3 frame period clocks", second - first, 192);
      pen[2] = 1'b1;

      // Random enables and occasional restarts on all three engines.
      for (int k = 0; k < 3000; k++) begin
         for (int id = 0; id < 3; id++) begin
            pen[id] = ($urandom_range(0, 3) != 0);
            rst[id] = ($urandom_range(0, 299) == 0);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
